// File: rtl/grayscale_stream_if.sv
// grayscale_stream_if
//   Stream bundle for grayscale_stream: one RGB input stream and one grey
//   output stream, plus the per-beat mode select and the frame counter.
//
//   Handshake: a beat moves across a port on the rising clock edge where
//   its valid and ready are both high. A producer keeps valid and payload
//   steady until that edge. ready may depend combinationally on the
//   downstream ready.
//
//   Signals
//     mode        : 0 = arithmetic mean, 1 = weighted luma (per input beat)
//     in_valid    : input beat valid
//     in_ready    : block accepts the input beat this cycle
//     in_rgb      : NUM_PIXELS lanes, lane k at 3*k*BIT_PER_PIXEL, {B,G,R} from LSB
//     in_last     : input beat is the last one of its frame
//     out_valid   : output beat valid
//     out_ready   : downstream accepts the output beat
//     out_gray    : NUM_PIXELS grey lanes, lane k at k*BIT_PER_PIXEL
//     out_last    : in_last of the same beat
//     frame_count : frames completed at the output (wraps at 16 bits)
//
//   Modports: master = stream source/sink side (testbench), slave = block.
interface grayscale_stream_if #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int NUM_PIXELS    = 9
);
    logic                                  mode;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [NUM_PIXELS*3*BIT_PER_PIXEL-1:0] in_rgb;
    logic                                  in_last;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_PIXELS*BIT_PER_PIXEL-1:0]   out_gray;
    logic                                  out_last;
    logic [15:0]                           frame_count;

    modport master (
        output mode, in_valid, in_rgb, in_last, out_ready,
        input  in_ready, out_valid, out_gray, out_last, frame_count
    );

    modport slave (
        input  mode, in_valid, in_rgb, in_last, out_ready,
        output in_ready, out_valid, out_gray, out_last, frame_count
    );
endinterface

// File: rtl/grayscale_stream.sv
// grayscale_stream
//   Converts NUM_PIXELS RGB lanes per beat to grey, two-stage pipeline.
//   S1 registers the per-lane component sum and the weighted luma sum
//   together with the beat's mode and last flag; S2 registers the selected
//   grey result and last. Full throughput of one beat per cycle with
//   out_ready high; backpressure stalls S2 first, then S1, then in_ready.
//
//   mean     = floor((R+G+B)/3)
//   weighted = floor((77R+150G+29B)/256)
//   With macro GRAYSCALE_ROUND_EN defined both round to nearest instead:
//   mean = floor((sum+1)/3), weighted = floor((w+128)/256). Latency and
//   interface are the same in both builds.
//
//   Ports
//     clk   : clock, rising edge
//     reset : synchronous, active-high; drops all in-flight beats
//     bus   : grayscale_stream_if.slave (streams, mode, frame_count)
module grayscale_stream #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int NUM_PIXELS    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    grayscale_stream_if.slave       bus
);
    localparam int B  = BIT_PER_PIXEL;
    localparam int SW = B + 2;          // R+G+B never exceeds 3*(2^B-1)
    localparam int WW = B + 8;          // weights add up to 256
    localparam int GW = NUM_PIXELS * B;

`ifdef GRAYSCALE_ROUND_EN
    localparam logic [SW-1:0] MEAN_BIAS = SW'(1);
    localparam logic [WW-1:0] LUMA_BIAS = WW'(128);
`else
    localparam logic [SW-1:0] MEAN_BIAS = '0;
    localparam logic [WW-1:0] LUMA_BIAS = '0;
`endif

    logic          s1_adv, s2_adv, in_ready_c, in_fire;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_mode_q,  s1_mode_d;
    logic          s1_last_q,  s1_last_d;
    logic [SW-1:0] s1_sum_q  [NUM_PIXELS];
    logic [SW-1:0] s1_sum_d  [NUM_PIXELS];
    logic [WW-1:0] s1_luma_q [NUM_PIXELS];
    logic [WW-1:0] s1_luma_d [NUM_PIXELS];

    logic          s2_valid_q, s2_valid_d;
    logic          s2_last_q,  s2_last_d;
    logic [GW-1:0] s2_gray_q,  s2_gray_d;

    logic [15:0]   frame_count_q, frame_count_d;

    logic [SW-1:0] lane_sum  [NUM_PIXELS];
    logic [WW-1:0] lane_luma [NUM_PIXELS];
    logic [GW-1:0] lane_gray;

    // Per-lane arithmetic: sums from the input bus feed S1, the divide and
    // mode select work on S1 contents and feed S2.
    for (genvar k = 0; k < NUM_PIXELS; k++) begin : g_lane
        logic [B-1:0] b_c, g_c, r_c;
        assign b_c = bus.in_rgb[(3*k)*B   +: B];
        assign g_c = bus.in_rgb[(3*k+1)*B +: B];
        assign r_c = bus.in_rgb[(3*k+2)*B +: B];

        assign lane_sum[k]  = SW'(r_c) + SW'(g_c) + SW'(b_c);
        assign lane_luma[k] = WW'(77) * WW'(r_c) + WW'(150) * WW'(g_c)
                            + WW'(29) * WW'(b_c);

        // Both quotients fit in B bits, so no saturation is needed.
        assign lane_gray[k*B +: B] = s1_mode_q
            ? B'((s1_luma_q[k] + LUMA_BIAS) >> 8)
            : B'((s1_sum_q[k] + MEAN_BIAS) / SW'(3));
    end

    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        // Held low while reset is high so nothing is taken during reset.
        in_ready_c = !reset && s1_adv;
        in_fire    = bus.in_valid && in_ready_c;

        s1_valid_d    = s1_valid_q;
        s1_mode_d     = s1_mode_q;
        s1_last_d     = s1_last_q;
        s1_sum_d      = s1_sum_q;
        s1_luma_d     = s1_luma_q;
        s2_valid_d    = s2_valid_q;
        s2_last_d     = s2_last_q;
        s2_gray_d     = s2_gray_q;
        frame_count_d = frame_count_q;

        if (s1_adv) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_sum_d  = lane_sum;
                s1_luma_d = lane_luma;
                s1_mode_d = bus.mode;
                s1_last_d = bus.in_last;
            end
        end

        // S2 payload only changes when it advances, so it holds under stall.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_gray_d = lane_gray;
                s2_last_d = s1_last_q;
            end
        end

        if (s2_valid_q && bus.out_ready && s2_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_mode_q     <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_sum_q      <= '{default: '0};
            s1_luma_q     <= '{default: '0};
            s2_valid_q    <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_gray_q     <= '0;
            frame_count_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_mode_q     <= s1_mode_d;
            s1_last_q     <= s1_last_d;
            s1_sum_q      <= s1_sum_d;
            s1_luma_q     <= s1_luma_d;
            s2_valid_q    <= s2_valid_d;
            s2_last_q     <= s2_last_d;
            s2_gray_q     <= s2_gray_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_gray    = s2_gray_q;
    assign bus.out_last    = s2_last_q;
    assign bus.frame_count = frame_count_q;
endmodule
